// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with a 256x8 data memory and the MEM/WB register.
//   clock, reset            : clock, synchronous active-high reset
//   stall, flush            : hold the stage / insert a bubble into MEM/WB
//   valid_in, WR_in, RM_in,
//   MW_in, ACIN, WDATA, rd_in : instruction arriving from EX (ACIN doubles as address)
//   ACOUT, MEMOUT, WR, RM,
//   rd, valid_out           : MEM/WB register contents driven to WB
//   fwd_valid, fwd_rd,
//   fwd_data                : forwarding path to EX
// Optional feature: define MEMSTAGE_FWD_EN to enable the forwarding path;
// otherwise the fwd_* ports are tied to zero.
module mem_stage (
    input  logic       clock,
    input  logic       reset,
    input  logic       stall,
    input  logic       flush,
    input  logic       valid_in,
    input  logic       WR_in,
    input  logic       RM_in,
    input  logic       MW_in,
    input  logic [7:0] ACIN,
    input  logic [7:0] WDATA,
    input  logic [1:0] rd_in,
    output logic [7:0] ACOUT,
    output logic [7:0] MEMOUT,
    output logic       WR,
    output logic       RM,
    output logic [1:0] rd,
    output logic       valid_out,
    output logic       fwd_valid,
    output logic [1:0] fwd_rd,
    output logic [7:0] fwd_data
);

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 256;

    // Data memory; zero at time 0 and deliberately not cleared by reset.
    logic [DW-1:0] mem_q [0:DEPTH-1] = '{default: '0};

    logic [DW-1:0] acout_q, acout_d;
    logic [DW-1:0] memout_q, memout_d;
    logic          wr_q, wr_d;
    logic          rm_q, rm_d;
    logic [1:0]    rd_q, rd_d;
    logic          valid_q, valid_d;
    logic          mem_we_c;

    // Store only for a real instruction on an advancing, non-reset edge.
    assign mem_we_c = valid_in && MW_in && !stall && !flush && !reset;

    // Next-state of MEM/WB: flush kills valid/WR only, stall holds everything.
    always_comb begin
        acout_d  = acout_q;
        memout_d = memout_q;
        wr_d     = wr_q;
        rm_d     = rm_q;
        rd_d     = rd_q;
        valid_d  = valid_q;
        if (flush) begin
            valid_d = 1'b0;
            wr_d    = 1'b0;
        end else if (!stall) begin
            acout_d  = ACIN;
            memout_d = mem_q[ACIN];   // pre-write contents: store+load returns old data
            wr_d     = WR_in && valid_in;
            rm_d     = RM_in;
            rd_d     = rd_in;
            valid_d  = valid_in;
        end
    end

    // MEM/WB register.
    always_ff @(posedge clock) begin
        if (reset) begin
            acout_q  <= '0;
            memout_q <= '0;
            wr_q     <= 1'b0;
            rm_q     <= 1'b0;
            rd_q     <= '0;
            valid_q  <= 1'b0;
        end else begin
            acout_q  <= acout_d;
            memout_q <= memout_d;
            wr_q     <= wr_d;
            rm_q     <= rm_d;
            rd_q     <= rd_d;
            valid_q  <= valid_d;
        end
    end

    // Synchronous memory write.
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            mem_q[ACIN] <= WDATA;
        end
    end

    assign ACOUT     = acout_q;
    assign MEMOUT    = memout_q;
    assign WR        = wr_q;
    assign RM        = rm_q;
    assign rd        = rd_q;
    assign valid_out = valid_q;

`ifdef MEMSTAGE_FWD_EN
    // Forward whatever WB is about to write back.
    assign fwd_valid = valid_q && wr_q;
    assign fwd_rd    = rd_q;
    assign fwd_data  = rm_q ? memout_q : acout_q;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = 2'b00;
    assign fwd_data  = 8'h00;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic       clock = 1'b0;
    logic       reset, stall, flush, valid_in, WR_in, RM_in, MW_in;
    logic [7:0] ACIN, WDATA;
    logic [1:0] rd_in;
    logic [7:0] ACOUT, MEMOUT, fwd_data;
    logic       WR, RM, valid_out, fwd_valid;
    logic [1:0] rd, fwd_rd;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .WR_in(WR_in), .RM_in(RM_in), .MW_in(MW_in),
        .ACIN(ACIN), .WDATA(WDATA), .rd_in(rd_in),
        .ACOUT(ACOUT), .MEMOUT(MEMOUT), .WR(WR), .RM(RM), .rd(rd),
        .valid_out(valid_out), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic wr, input logic rm, input logic mw,
                         input logic [7:0] a, input logic [7:0] d, input logic [1:0] r);
        valid_in = v; WR_in = wr; RM_in = rm; MW_in = mw;
        ACIN = a; WDATA = d; rd_in = r;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_acout"}, ACOUT, 8'h00);
        check({tag, "_memout"}, MEMOUT, 8'h00);
        check({tag, "_wr"}, {7'd0, WR}, 8'h00);
        check({tag, "_rm"}, {7'd0, RM}, 8'h00);
        check({tag, "_rd"}, {6'd0, rd}, 8'h00);
        check({tag, "_valid"}, {7'd0, valid_out}, 8'h00);
        check({tag, "_fwd_valid"}, {7'd0, fwd_valid}, 8'h00);
        check({tag, "_fwd_rd"}, {6'd0, fwd_rd}, 8'h00);
        check({tag, "_fwd_data"}, fwd_data, 8'h00);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
        #2;
        step();
        step();
        check_all_zero("reset");

        // Store 0xA5 to 0x10; MEMOUT shows pre-write contents (0).
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'hA5, 2'd1);
        step();
        check("st_valid", {7'd0, valid_out}, 8'h01);
        check("st_wr", {7'd0, WR}, 8'h00);
        check("st_acout", ACOUT, 8'h10);
        check("st_memout_old", MEMOUT, 8'h00);
        check("st_rd", {6'd0, rd}, 8'h01);

        // Load 0x10 immediately after: returns stored value.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 2'd3);
        step();
        check("ld_memout", MEMOUT, 8'hA5);
        check("ld_rm", {7'd0, RM}, 8'h01);
        check("ld_wr", {7'd0, WR}, 8'h01);
        check("ld_rd", {6'd0, rd}, 8'h03);
`ifdef MEMSTAGE_FWD_EN
        check("ld_fwd_data", fwd_data, 8'hA5);
`endif

        // Stall 3 cycles with a store to 0x20 presented: outputs frozen.
        stall = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 8'h3C, 2'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_acout", ACOUT, 8'h10);
            check("stall_memout", MEMOUT, 8'hA5);
            check("stall_wr", {7'd0, WR}, 8'h01);
            check("stall_rd", {6'd0, rd}, 8'h03);
        end
        // Release: store happens now; old data 0 proves no write during stall.
        stall = 1'b0;
        step();
        check("rel_acout", ACOUT, 8'h20);
        check("rel_memout_old", MEMOUT, 8'h00);
        check("rel_wr", {7'd0, WR}, 8'h00);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 2'd2);
        step();
        check("rel_load", MEMOUT, 8'h3C);

        // Flush + stall with a store to 0x30: bubble, other fields held.
        flush = 1'b1; stall = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h30, 8'h99, 2'd1);
        step();
        check("flush_valid", {7'd0, valid_out}, 8'h00);
        check("flush_wr", {7'd0, WR}, 8'h00);
        check("flush_acout_held", ACOUT, 8'h20);
        check("flush_memout_held", MEMOUT, 8'h3C);
        check("flush_rd_held", {6'd0, rd}, 8'h02);
        flush = 1'b0; stall = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h30, 8'h00, 2'd0);
        step();
        check("flush_mem_unchanged", MEMOUT, 8'h00);

        // Bubble with WR_in=1 never asserts WR; fields still registered.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 8'h00, 2'd1);
        step();
        check("bubble_wr", {7'd0, WR}, 8'h00);
        check("bubble_valid", {7'd0, valid_out}, 8'h00);
        check("bubble_acout", ACOUT, 8'h55);
        check("bubble_fwd_valid", {7'd0, fwd_valid}, 8'h00);

        // Reset with a pending store: outputs cleared, memory preserved.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 8'h77, 2'd1);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 8'h11, 2'd3);
        reset = 1'b1;
        step();
        check_all_zero("rst_mid");
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 2'd0);
        step();
        check("rst_mem_kept", MEMOUT, 8'h77);
        check("rst_resume_valid", {7'd0, valid_out}, 8'h01);

        // Forwarding of an ALU result.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h00, 2'd2);
        step();
`ifdef MEMSTAGE_FWD_EN
        check("fwd_valid", {7'd0, fwd_valid}, 8'h01);
        check("fwd_rd", {6'd0, fwd_rd}, 8'h02);
        check("fwd_data", fwd_data, 8'h5A);
`else
        check("fwd_valid_off", {7'd0, fwd_valid}, 8'h00);
        check("fwd_rd_off", {6'd0, fwd_rd}, 8'h00);
        check("fwd_data_off", fwd_data, 8'h00);
`endif
        check("fwd_acout", ACOUT, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have the port `clock`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port `reset`, input, 1 bit: synchronous, active-high reset, sampled on the `clock` rising edge.
REQ-003 The block SHALL have the port `stall`, input, 1 bit: hold the stage; no state change, no memory write.
REQ-004 The block SHALL have the port `flush`, input, 1 bit: insert a bubble into the MEM/WB register; no memory write.
REQ-005 The block SHALL have the port `valid_in`, input, 1 bit: the upstream instruction is real (not a bubble).
REQ-006 The block SHALL have the port `WR_in`, input, 1 bit: the instruction writes the register file.
REQ-007 The block SHALL have the port `RM_in`, input, 1 bit: register source select; 1 = memory data, 0 = accumulator result.
REQ-008 The block SHALL have the port `MW_in`, input, 1 bit: the instruction stores to data memory.
REQ-009 The block SHALL have the port `ACIN`, input, 8 bits: ALU/accumulator result, which is also the memory address.
REQ-010 The block SHALL have the port `WDATA`, input, 8 bits: store data.
REQ-011 The block SHALL have the port `rd_in`, input, 2 bits: destination register index.
REQ-012 The block SHALL have the port `ACOUT`, output, 8 bits: registered accumulator result to WB.
REQ-013 The block SHALL have the port `MEMOUT`, output, 8 bits: registered load data to WB.
REQ-014 The block SHALL have the ports `WR`, output, 1 bit, and `RM`, output, 1 bit: registered write enable and source select to WB.
REQ-015 The block SHALL have the port `rd`, output, 2 bits: registered destination register index to WB.
REQ-016 The block SHALL have the port `valid_out`, output, 1 bit: the MEM/WB register holds a real instruction.
REQ-017 The block SHALL have the ports `fwd_valid`, output, 1 bit; `fwd_rd`, output, 2 bits; and `fwd_data`, output, 8 bits: forwarding path to EX (see Configuration).

Function
REQ-018 The block SHALL contain a data memory of 256 x 8 bits, addressed by ACIN, zero at time 0; read is combinational and write is synchronous.
REQ-019 The block SHALL have a latency of exactly one cycle: inputs sampled at edge N appear on ACOUT/MEMOUT/WR/RM/rd/valid_out after edge N.
REQ-020 The block SHALL write data memory at the edge only when valid_in=1, MW_in=1, stall=0, flush=0 and reset=0, using mem[ACIN] <= WDATA.
REQ-021 The block SHALL take MEMOUT from the pre-write contents of mem[ACIN]; a load following a store to the same address on the next cycle SHALL return the stored value.
REQ-022 The block SHALL, when an instruction has both MW_in=1 and RM_in=1, perform the store and return the old data on MEMOUT.
REQ-023 The block SHALL, when stall=1 and flush=0, hold all outputs and leave memory unchanged.
REQ-024 The block SHALL, when flush=1, set valid_out=0 and WR=0 on that edge and leave the other outputs unchanged; flush takes priority over stall.
REQ-025 The block SHALL gate WR as WR_in AND valid_in; a bubble SHALL never assert WR.
REQ-026 The block SHALL register the remaining fields (RM, rd, ACOUT, MEMOUT) regardless of valid_in.
REQ-027 The block SHALL apply the priority order reset > flush > stall > normal advance.

Reset
REQ-028 The block SHALL, on reset, set ACOUT=0, MEMOUT=0, WR=0, RM=0, rd=0, valid_out=0, fwd_valid=0, fwd_rd=0 and fwd_data=0.
REQ-029 The block SHALL preserve memory contents across reset and SHALL block any write in the reset cycle.
REQ-030 The block SHALL treat reset mid-stall or mid-flush as a plain reset, and the stage SHALL resume on the first edge after reset deasserts.

Configuration
REQ-031 When MEMSTAGE_FWD_EN is defined, the block SHALL drive fwd_valid=valid_out&WR, fwd_rd=rd, and fwd_data=RM?MEMOUT:ACOUT, combinationally from the MEM/WB register.
REQ-032 When MEMSTAGE_FWD_EN is undefined, the block SHALL keep the fwd_* ports present and tie them constantly to 0, with no forwarding mux instantiated.

Verification
REQ-033 The bench SHALL cover: store ACIN=0x10, WDATA=0xA5, MW=1, then load ACIN=0x10, RM=1 -> MEMOUT=0xA5 one cycle after the load.
REQ-034 The bench SHALL cover: stall=1 for 3 cycles with a store ACIN=0x20, WDATA=0x3C presented, then release -> exactly one write, mem[0x20]=0x3C, outputs frozen during the stall.
REQ-035 The bench SHALL cover: flush=1 and stall=1 together with a store to 0x30 -> valid_out=0, WR=0, mem[0x30] unchanged.
REQ-036 The bench SHALL cover: valid_in=0, WR_in=1 -> WR=0 and valid_out=0 on the next cycle.
REQ-037 The bench SHALL cover: reset asserted while mem[0x40]=0x77 with a pending store of 0x11 -> all outputs 0, mem[0x40] still 0x77.
REQ-038 The bench SHALL cover, with MEMSTAGE_FWD_EN defined: an ALU result of 0x5A, rd_in=2, WR_in=1 -> fwd_valid=1, fwd_rd=2, fwd_data=0x5A one cycle later; with the macro undefined -> all fwd_* = 0.
